multichannel_capture_buffer: RTL and testbench
==============================================

# multichannel_capture_buffer

Parametrised multi-channel sample capture buffer for the three-phase power analyzer. It stores CH channels of W-bit samples, such as load-side voltage and current ADC codes, into per-channel RAMs on an armed, optionally level-triggered single-shot acquisition. It then freezes the record and serves two independent read ports: a random-access host port for the Nios file-streaming path, and a strided scan port for the VGA waveform renderer.

## Interface
Parameters:
- CH, 6, number of channels
- W, 8, sample width per channel
- DEPTH, 4096, samples per channel (power of two, ≥ 2)
- AW, $clog2(DEPTH), address width
- STRIDE, 4, scan-port address increment per clk
- SCAN_LIMIT, 1615, scan address at or above which the scan wraps to 0 (< DEPTH)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- arm  in  1  single-cycle pulse: start/restart an acquisition
- abort  in  1  single-cycle pulse: return to IDLE
- trig_en  in  1  1 = wait for rising crossing on channel 0; 0 = start on first sample
- trig_level  in  W  unsigned trigger threshold
- sample_valid  in  1  one-cycle strobe, already synchronous to clk
- sample_data  in  CH*W  channel k in bits [k*W +: W]
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- done  out  1  record complete and frozen
- fill  out  AW+1  samples written in current record
- rd_addr  in  AW  host read address
- rd_ch  in  $clog2(CH)  host channel select
- rd_data  out  W  host read data
- scan_en  in  1  scan active (display read window)
- scan_data  out  CH*W  all channels at scan address

## Operation
- IDLE: no writes. `arm` moves to ARMED, clears fill, write pointer = 0, and clears the channel-0 history valid flag.
- ARMED, trig_en=0: the first sample_valid writes at address 0. fill becomes 1 and the state moves to CAPTURE.
- ARMED, trig_en=1: on each sample_valid, the previous channel-0 sample is held. A trigger is prev < trig_level AND cur ≥ trig_level, evaluated unsigned.
  - The first sample after arm has no history and can never trigger.
  - The trigger sample is written at address 0, fill becomes 1, and the state moves to CAPTURE.
- CAPTURE: each sample_valid writes all CH channels at the write pointer, then increments the pointer and fill. The write that makes fill = DEPTH moves the state to DONE. Memory is never overwritten after that.
- DONE: frozen. Only arm (new record) or abort leave this state.
- arm in ARMED or CAPTURE restarts: the state becomes ARMED, fill is 0, the pointer is 0, and history is invalidated.
- abort in any state goes to IDLE; fill is kept.
- Simultaneous arm and abort: abort wins.
- A sample_valid in the same cycle as arm or abort is discarded.
- Host port: reads are allowed in any state. Data is defined only in DONE, or for addresses below fill.
- Scan port: the scan address increments by STRIDE each clk while scan_en=1. When the current address is ≥ SCAN_LIMIT, the next address is 0. scan_en=0 forces the address to 0.

## Timing
- Reset values: state=IDLE, done=0, fill=0, write pointer=0, scan address=0, rd_data=0, scan_data=0, history invalid.
- State transitions take effect on the clk edge that samples the causing input. For example, arm at edge n gives state=ARMED after edge n.
- done = (state==DONE), combinational from the state register.
- Write commits on the sample_valid edge. fill updates on the same edge.
- rd_data: 1-cycle latency from rd_addr/rd_ch (registered RAM output, registered channel mux select).
- scan_data: 1-cycle latency from the scan address. First beat after scan_en rises is address 0.
- Read-during-write to the same address: returns old data (verify not required).
- Reset mid-capture: contents undefined, all control returns to reset values.

## Structure
- Package capture_pkg holds the state enum (IDLE, ARMED, CAPTURE, DONE) and the channel-slice helper function.
- Sub-module capture_ram: one write port, two registered read ports, W×DEPTH. Instantiate it CH times in a generate loop; the host mux sits outside.
- The trigger detector, pointer/fill counter, and scan counter live in the top level.

## Test plan
- Reset then arm with trig_en=0, DEPTH=16, 16 strobes of ramp data (ch k = 10*k + i) → state CAPTURE→DONE on the 16th strobe, fill=16. Host read ch2 addr 5 gives 25 one cycle later.
- trig_en=1, level=100, ch0 sequence 120, 90, 99, 100, 150 → 120 does not trigger (no history). Trigger fires on 100; address 0 holds 100, address 1 holds 150.
- Mid-CAPTURE arm after 7 samples → state ARMED, fill=0; the next record starts at address 0. Arm plus abort in the same cycle → IDLE.
- DONE then 20 further strobes → fill stays at DEPTH, memory unchanged, state DONE.
- scan_en high with STRIDE=4, SCAN_LIMIT=12 → addresses 0, 4, 8, 12, 0, 4… with data lagging one cycle. Dropping scan_en gives address 0 on the next cycle.
- Reset asserted during CAPTURE → all outputs return to reset values on the next edge; a subsequent arm works normally.

Source files
------------

// File: rtl/multichannel_capture_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : capture_pkg                                                 |
// | Capture-buffer state encoding and channel slicing helper.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    // LSB position of channel k inside a packed CH*W sample word.
    function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multichannel_capture_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : multichannel_capture_buffer_if                            |
// | Acquisition control, sample stream, host read and scan read ports.    |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
interface multichannel_capture_buffer_if #(
    parameter int CH = 6,
    parameter int W  = 8,
    parameter int AW = 12,
    parameter int CW = (CH > 1) ? $clog2(CH) : 1
);
    logic              arm;
    logic              abort;
    logic              trig_en;
    logic [W-1:0]      trig_level;
    logic              sample_valid;
    logic [CH*W-1:0]   sample_data;
    logic [1:0]        state;
    logic              done;
    logic [AW:0]       fill;
    logic [AW-1:0]     rd_addr;
    logic [CW-1:0]     rd_ch;
    logic [W-1:0]      rd_data;
    logic              scan_en;
    logic [CH*W-1:0]   scan_data;

    modport master (
        output arm, abort, trig_en, trig_level, sample_valid, sample_data,
               rd_addr, rd_ch, scan_en,
        input  state, done, fill, rd_data, scan_data
    );

    modport slave (
        input  arm, abort, trig_en, trig_level, sample_valid, sample_data,
               rd_addr, rd_ch, scan_en,
        output state, done, fill, rd_data, scan_data
    );
endinterface
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : capture_ram                                                 |
// | One-channel sample RAM: one write port, two registered read ports.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module capture_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          we,
    input  wire logic [AW-1:0] wa,
    input  wire logic [W-1:0]  wd,
    input  wire logic [AW-1:0] ra_addr,
    output logic      [W-1:0]  ra_data,
    input  wire logic [AW-1:0] rb_addr,
    output logic      [W-1:0]  rb_data
);

    logic [W-1:0] r_mem [DEPTH];

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ra_data <= '0;
            rb_data <= '0;
        end else begin
            ra_data <= r_mem[ra_addr];
            rb_data <= r_mem[rb_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/multichannel_capture_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multichannel_capture_buffer                                 |
// | Armed single-shot multi-channel capture with host and scan readout.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module multichannel_capture_buffer
    import capture_pkg::*;
#(
    parameter int CH         = 6,
    parameter int W          = 8,
    parameter int DEPTH      = 4096,
    parameter int AW         = $clog2(DEPTH),
    parameter int STRIDE     = 4,
    parameter int SCAN_LIMIT = 1615
) (
    input  wire logic clk,
    input  wire logic reset,
    multichannel_capture_buffer_if.slave bus
);

    localparam int          CW          = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [AW:0] c_last_fill = (AW+1)'(DEPTH - 1);

    cap_state_t      r_state;
    cap_state_t      w_state_next;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_fill;
    logic [W-1:0]    r_hist;
    logic            r_hist_valid;
    logic [AW-1:0]   r_scan_addr;
    logic [CW-1:0]   r_rd_ch;

    logic            w_ctrl;
    logic [W-1:0]    w_ch0;
    logic            w_trig_hit;
    logic            w_start;
    logic            w_wr_en;
    logic [W-1:0]    w_host_q [CH];
    logic [W-1:0]    w_scan_q [CH];
    logic [W-1:0]    w_rd_mux;
    logic [CH*W-1:0] w_scan_pack;

    // Any control pulse swallows a coincident sample.
    assign w_ctrl     = bus.arm | bus.abort;
    assign w_ch0      = bus.sample_data[W-1:0];
    assign w_trig_hit = r_hist_valid && (r_hist < bus.trig_level) && (w_ch0 >= bus.trig_level);
    assign w_start    = (r_state == ARMED) && bus.sample_valid && !w_ctrl &&
                        (!bus.trig_en || w_trig_hit);
    assign w_wr_en    = bus.sample_valid && !w_ctrl && ((r_state == CAPTURE) || w_start);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.abort) begin
            w_state_next = IDLE;
        end else if (bus.arm) begin
            w_state_next = ARMED;
        end else begin
            case (r_state)
                ARMED:   if (w_start) w_state_next = CAPTURE;
                CAPTURE: if (w_wr_en && (r_fill == c_last_fill)) w_state_next = DONE;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_hist       <= '0;
            r_hist_valid <= 1'b0;
        end else if (bus.arm && !bus.abort) begin
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_hist_valid <= 1'b0;
        end else if (!w_ctrl) begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_fill   <= r_fill + (AW+1)'(1);
            end
            if (bus.sample_valid && (r_state == ARMED)) begin
                r_hist       <= w_ch0;
                r_hist_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scan_addr <= '0;
            r_rd_ch     <= '0;
        end else begin
            r_rd_ch <= bus.rd_ch;
            if (!bus.scan_en || (r_scan_addr >= AW'(SCAN_LIMIT))) begin
                r_scan_addr <= '0;
            end else begin
                r_scan_addr <= r_scan_addr + AW'(STRIDE);
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        capture_ram #(
            .W     (W),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk     (clk),
            .reset   (reset),
            .we      (w_wr_en),
            .wa      (r_wr_ptr),
            .wd      (bus.sample_data[ch_lsb(k, W) +: W]),
            .ra_addr (bus.rd_addr),
            .ra_data (w_host_q[k]),
            .rb_addr (r_scan_addr),
            .rb_data (w_scan_q[k])
        );
    end

    // Out-of-range channel selects read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < CH; k++) begin
            if (r_rd_ch == CW'(k)) w_rd_mux = w_host_q[k];
        end
    end

    always_comb begin
        w_scan_pack = '0;
        for (int k = 0; k < CH; k++) begin
            w_scan_pack[k*W +: W] = w_scan_q[k];
        end
    end

    assign bus.state     = r_state;
    assign bus.done      = (r_state == DONE);
    assign bus.fill      = r_fill;
    assign bus.rd_data   = w_rd_mux;
    assign bus.scan_data = w_scan_pack;

endmodule
`default_nettype wire

// File: tb/tb_multichannel_capture_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_multichannel_capture_buffer                              |
// | Directed vector bench for the capture buffer (DEPTH=16 build).        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_multichannel_capture_buffer;

    localparam int CH = 6;
    localparam int W  = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multichannel_capture_buffer_if #(.CH(CH), .W(W), .AW(AW)) bus ();

    multichannel_capture_buffer #(
        .CH(CH), .W(W), .DEPTH(DEPTH), .AW(AW), .STRIDE(4), .SCAN_LIMIT(12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rst_n;
        bit          arm;
        bit          abort;
        bit          ten;
        logic [7:0]  lvl;
        bit          sv;
        logic [47:0] sd;
        logic [2:0]  rch;
        logic [3:0]  raddr;
        bit          sen;
        logic [1:0]  st;
        logic [4:0]  fill;
        bit          crd;
        logic [7:0]  erd;
        bit          csc;
        logic [47:0] esc;
    } vec_t;

    vec_t vq[$];
    int   n_app  = 0;
    int   n_miss = 0;

    // Channel k carries d0 + 10*k.
    function automatic logic [47:0] row(input logic [7:0] d0);
        logic [47:0] r;
        for (int k = 0; k < CH; k++) r[k*8 +: 8] = d0 + 8'(10*k);
        return r;
    endfunction

    task automatic add(input bit rn, input bit a, input bit ab, input bit te,
                       input logic [7:0] lv, input bit sv, input logic [7:0] d0,
                       input logic [1:0] st, input logic [4:0] fl);
        vec_t v;
        v = '{rst_n: rn, arm: a, abort: ab, ten: te, lvl: lv, sv: sv, sd: row(d0),
              rch: 3'd0, raddr: 4'd0, sen: 1'b0, st: st, fill: fl,
              crd: 1'b0, erd: 8'd0, csc: 1'b0, esc: 48'd0};
        vq.push_back(v);
    endtask

    task automatic rd(input logic [2:0] ch, input logic [3:0] addr, input logic [7:0] e);
        vq[vq.size()-1].rch   = ch;
        vq[vq.size()-1].raddr = addr;
        vq[vq.size()-1].crd   = 1'b1;
        vq[vq.size()-1].erd   = e;
    endtask

    task automatic sc(input bit en, input logic [47:0] e);
        vq[vq.size()-1].sen = en;
        vq[vq.size()-1].csc = 1'b1;
        vq[vq.size()-1].esc = e;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_app++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset            = v.rst_n;
        bus.arm          = v.arm;
        bus.abort        = v.abort;
        bus.trig_en      = v.ten;
        bus.trig_level   = v.lvl;
        bus.sample_valid = v.sv;
        bus.sample_data  = v.sd;
        bus.rd_ch        = v.rch;
        bus.rd_addr      = v.raddr;
        bus.scan_en      = v.sen;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] trig_seq [5];
        logic [1:0] trig_st  [5];
        logic [4:0] trig_fl  [5];
        logic [7:0] bnd_seq  [5];
        logic [7:0] scan_d   [10];
        bit         scan_e   [10];
        vec_t       v;
        int         n;
        bit         seen;

        // Reset
        add(0,0,0,0,0,0,0, 0,0); rd(0,0,0); sc(0,48'd0);
        add(0,0,0,0,0,0,0, 0,0); rd(0,0,0); sc(0,48'd0);
        // Free-running record of ramp data
        add(1,1,0,0,0,0,0, 1,0);
        for (int i = 0; i < 16; i++) begin
            add(1,0,0,0,0,1,8'(i), (i == 15) ? 2'd3 : 2'd2, 5'(i+1));
            if (i == 10) rd(1,3,13);
        end
        add(1,0,0,0,0,0,0, 3,16); rd(2,5,25);
        add(1,0,0,0,0,0,0, 3,16); rd(0,15,15);
        add(1,0,0,0,0,0,0, 3,16); rd(5,0,50);
        // Scan walk 0,4,8,12,0,4 then drop enable, then re-enable
        scan_d = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd0, 8'd4, 8'd8, 8'd0, 8'd0, 8'd4};
        scan_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            add(1,0,0,0,0,0,0, 3,16); sc(scan_e[i], row(scan_d[i]));
        end
        // Frozen record ignores further strobes
        for (int i = 0; i < 20; i++) add(1,0,0,0,0,1,8'(200+i), 3,16);
        add(1,0,0,0,0,0,0, 3,16); rd(2,5,25);
        add(1,0,0,0,0,0,0, 3,16); rd(4,12,52);
        add(1,0,0,0,0,0,0, 3,16); rd(0,0,0);
        // Level trigger: first sample has no history, fires on 99 -> 100
        add(1,1,0,1,100,0,0, 1,0);
        trig_seq = '{8'd120, 8'd90, 8'd99, 8'd100, 8'd150};
        trig_st  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        trig_fl  = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd2};
        for (int i = 0; i < 5; i++) add(1,0,0,1,100,1,trig_seq[i], trig_st[i], trig_fl[i]);
        add(1,0,0,1,100,0,0, 2,2); rd(0,0,100);
        add(1,0,0,1,100,0,0, 2,2); rd(0,1,150);
        add(1,0,0,1,100,0,0, 2,2); rd(3,1,180);
        // Equal-to-level history does not arm a crossing
        add(1,1,0,1,50,0,0, 1,0);
        bnd_seq = '{8'd50, 8'd50, 8'd60, 8'd49, 8'd51};
        for (int i = 0; i < 5; i++) add(1,0,0,1,50,1,bnd_seq[i], (i == 4) ? 2'd2 : 2'd1, (i == 4) ? 5'd1 : 5'd0);
        // Restart mid-capture, discarded coincident samples, abort priority
        add(1,1,0,0,0,0,0, 1,0);
        for (int i = 0; i < 7; i++) add(1,0,0,0,0,1,8'(30+i), 2, 5'(i+1));
        add(1,1,0,0,0,1,99, 1,0);
        add(1,0,0,0,0,1,77, 2,1);
        add(1,0,0,0,0,0,0, 2,1); rd(0,0,77);
        add(1,0,0,0,0,1,78, 2,2);
        add(1,1,1,0,0,0,0, 0,2);
        add(1,0,0,0,0,1,5, 0,2);
        add(1,0,1,0,0,0,0, 0,2);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            step();
            chk($sformatf("v%0d.state", i), 64'(bus.state), 64'(vq[i].st));
            chk($sformatf("v%0d.done", i),  64'(bus.done),  64'(vq[i].st == 2'd3));
            chk($sformatf("v%0d.fill", i),  64'(bus.fill),  64'(vq[i].fill));
            if (vq[i].crd) chk($sformatf("v%0d.rd_data", i), 64'(bus.rd_data), 64'(vq[i].erd));
            if (vq[i].csc) chk($sformatf("v%0d.scan_data", i), 64'(bus.scan_data), 64'(vq[i].esc));
        end

        // Reset in the middle of a capture, then a clean record
        v = vq[0];
        v.rst_n = 1; v.arm = 1;
        drive(v); step();
        v.arm = 0; v.sv = 1;
        for (int i = 0; i < 3; i++) begin
            v.sd = row(8'(60+i)); drive(v); step();
        end
        chk("mid.fill", 64'(bus.fill), 64'd3);
        chk("mid.state", 64'(bus.state), 64'd2);
        v.rst_n = 0; v.sen = 1; v.rch = 3'd1;
        drive(v); step();
        chk("rst.state", 64'(bus.state), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        chk("rst.fill", 64'(bus.fill), 64'd0);
        chk("rst.rd_data", 64'(bus.rd_data), 64'd0);
        chk("rst.scan_data", 64'(bus.scan_data), 64'd0);
        v.rst_n = 1; v.sv = 0; v.sen = 0; v.arm = 1;
        drive(v); step();
        chk("rearm.state", 64'(bus.state), 64'd1);
        v.arm = 0; v.sv = 1;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            v.sd = row(8'(100+n)); drive(v); step();
            n++;
            seen = bus.done;
        end
        chk("rearm.done_seen", 64'(seen), 64'd1);
        chk("rearm.strobes", 64'(n), 64'd16);
        chk("rearm.fill", 64'(bus.fill), 64'd16);
        v.sv = 0; v.rch = 3'd1; v.raddr = 4'd7;
        drive(v); step();
        chk("rearm.rd_data", 64'(bus.rd_data), 64'd117);

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
